// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, resolves operand
// forwarding from MEM/WB, detects load-use hazards and counts stall cycles.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              kill the held and the incoming instruction
//   id_valid/id_ready  decode handshake carrying id_pkt
//   fwd_m, fwd_w       MEM / WB producer buses used for forwarding
//   ex_valid/ex_ready  execute handshake for the held instruction
//   ex_alu_control     ALU control of the held instruction
//   ex_operand_1/2     ALU operands (selected and forwarded)
//   ex_store_data      forwarded rs2 value
//   ex_ctrl            pc, rd_addr, rd_we, is_load of the held instruction
//   stall_cycles       saturating count of hazard stall cycles
//
// Build option: ID_EX_FWD_EN enables MEM/WB forwarding and operand refresh;
// without it operands come from the held data and every in-flight
// dependency (held or MEM) stalls decode.

package id_ex_pkg;
    localparam int DW = 64;

    typedef struct packed {
        logic [3:0] op;
        logic       word;
    } alu_control_packet_t;

    typedef struct packed {
        logic [DW-1:0]       pc;
        logic [4:0]          rs1_addr;
        logic [4:0]          rs2_addr;
        logic                use_rs1;
        logic                use_rs2;
        logic [DW-1:0]       rs1_data;
        logic [DW-1:0]       rs2_data;
        logic [DW-1:0]       imm;
        logic                op1_sel;
        logic                op2_sel;
        alu_control_packet_t alu_control;
        logic [4:0]          rd_addr;
        logic                rd_we;
        logic                is_load;
    } id_ex_packet_t;

    typedef struct packed {
        logic [4:0]    rd_addr;
        logic          we;
        logic          is_load;
        logic [DW-1:0] data;
    } fwd_packet_t;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [4:0]    rd_addr;
        logic          rd_we;
        logic          is_load;
    } ex_ctrl_t;
endpackage

module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  id_ex_packet_t       id_pkt,
    input  fwd_packet_t         fwd_m,
    input  fwd_packet_t         fwd_w,
    output logic                ex_valid,
    input  logic                ex_ready,
    output alu_control_packet_t ex_alu_control,
    output logic [XLEN-1:0]     ex_operand_1,
    output logic [XLEN-1:0]     ex_operand_2,
    output logic [XLEN-1:0]     ex_store_data,
    output ex_ctrl_t            ex_ctrl,
    output logic [31:0]         stall_cycles
);

    id_ex_packet_t   held;
    logic            advance;
    logic            hazard;
    logic            hit_held;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            unused_bits;

    // Does the incoming instruction read the register written by the held one?
    assign hit_held = ex_valid && held.rd_we && (held.rd_addr != 5'd0) &&
                      ((id_pkt.use_rs1 && (id_pkt.rs1_addr == held.rd_addr)) ||
                       (id_pkt.use_rs2 && (id_pkt.rs2_addr == held.rd_addr)));

`ifdef ID_EX_FWD_EN
    // MEM wins over WB; a load in MEM has no data yet and is never chosen
    // (the load-use bubble guarantees the consumer waits for WB).
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]    addr,
        input logic [DW-1:0] reg_data,
        input fwd_packet_t   m,
        input fwd_packet_t   w
    );
        logic [XLEN-1:0] v;
        v = XLEN'(reg_data);
        if (addr == 5'd0)
            v = '0;
        else if (m.we && (m.rd_addr == addr) && !m.is_load)
            v = XLEN'(m.data);
        else if (w.we && (w.rd_addr == addr))
            v = XLEN'(w.data);
        return v;
    endfunction

    assign rs1_val = fwd_sel(held.rs1_addr, held.rs1_data, fwd_m, fwd_w);
    assign rs2_val = fwd_sel(held.rs2_addr, held.rs2_data, fwd_m, fwd_w);
    assign hazard  = id_valid && hit_held && held.is_load;

    assign unused_bits = ^{held.use_rs1, held.use_rs2};
`else
    logic hit_mem;

    // WB writes through the register file, so only held and MEM matter.
    assign hit_mem = fwd_m.we && (fwd_m.rd_addr != 5'd0) &&
                     ((id_pkt.use_rs1 && (id_pkt.rs1_addr == fwd_m.rd_addr)) ||
                      (id_pkt.use_rs2 && (id_pkt.rs2_addr == fwd_m.rd_addr)));

    assign rs1_val = XLEN'(held.rs1_data);
    assign rs2_val = XLEN'(held.rs2_data);
    assign hazard  = id_valid && (hit_held || hit_mem);

    assign unused_bits = ^{held.use_rs1, held.use_rs2,
                           held.rs1_addr, held.rs2_addr,
                           fwd_m.is_load, fwd_m.data, fwd_w};
`endif

    assign advance  = !ex_valid || ex_ready;
    assign id_ready = rst_n && advance && !hazard && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            held         <= '0;
            stall_cycles <= '0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (advance) begin
                ex_valid <= id_valid && id_ready;
                if (id_valid && id_ready)
                    held <= id_pkt;
            end
`ifdef ID_EX_FWD_EN
            else begin
                // Stalled in EX: latch forwarded values so a producer that
                // retires from WB meanwhile is not lost.
                held.rs1_data <= DW'(rs1_val);
                held.rs2_data <= DW'(rs2_val);
            end
`endif
            if (id_valid && hazard && !flush && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign ex_operand_1   = held.op1_sel ? XLEN'(held.pc) : rs1_val;
    assign ex_operand_2   = held.op2_sel ? XLEN'(held.imm) : rs2_val;
    assign ex_store_data  = rs2_val;
    assign ex_alu_control = held.alu_control;
    assign ex_ctrl        = '{pc: held.pc, rd_addr: held.rd_addr,
                              rd_we: held.rd_we, is_load: held.is_load};

endmodule
